// File: rtl/dmem_ctrl.sv
// Data-memory access controller: A/B arbitration, sub-word RMW, registered responses.
// Optional DMEM_CTRL_ERR_EN enables out-of-range error reporting on err outputs.
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    a_req_i,
    input  logic                    a_we_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_wd_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    output logic                    a_gnt_o,
    output logic                    a_rvalid_o,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    output logic                    a_err_o,
    input  logic                    b_req_i,
    input  logic                    b_we_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   b_wd_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    output logic                    b_gnt_o,
    output logic                    b_rvalid_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    output logic                    b_err_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wd_o,
    input  logic [DATA_WIDTH-1:0]   mem_rd_i
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS * 4);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wait_q;
    logic [DATA_WIDTH-1:0] cap_rd_q, cap_wd_q;
    logic [BW-1:0]         cap_be_q;
    logic [ADDR_WIDTH-1:0] cap_addr_q;
    logic                  cap_port_q;

    logic                  win_b, w_we, oor, partial;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wd, merged;
    logic [BW-1:0]         w_be;
    logic                  resp_v, resp_port;
    logic [DATA_WIDTH-1:0] resp_data;
`ifdef DMEM_CTRL_ERR_EN
    logic                  resp_err;
`endif

    always_comb begin
        a_gnt_o    = 1'b0;
        b_gnt_o    = 1'b0;
        state_d    = state_q;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        partial    = 1'b0;
        resp_v     = 1'b0;
        resp_port  = 1'b0;
        resp_data  = '0;
`ifdef DMEM_CTRL_ERR_EN
        resp_err   = 1'b0;
`endif
        // B overrides A only once it has waited MAX_WAIT cycles
        win_b  = b_req_i && (!a_req_i || wait_q == WAIT_MAX);
        w_we   = win_b ? b_we_i   : a_we_i;
        w_addr = win_b ? b_addr_i : a_addr_i;
        w_wd   = win_b ? b_wd_i   : a_wd_i;
        w_be   = win_b ? b_be_i   : a_be_i;
        oor    = {1'b0, w_addr} >= LIMIT;
        merged = cap_rd_q;
        for (int i = 0; i < BW; i++) begin
            if (cap_be_q[i]) merged[8*i +: 8] = cap_wd_q[8*i +: 8];
        end
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (a_req_i || b_req_i) begin
                        a_gnt_o    = !win_b;
                        b_gnt_o    = win_b;
                        mem_addr_o = {w_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (w_we && !oor && &w_be) begin
                            mem_we_o = 1'b1;
                            mem_wd_o = w_wd;
                        end
                        partial = w_we && !oor && |w_be && !(&w_be);
                        if (partial) begin
                            state_d = RMW_WR;
                        end else begin
                            resp_v    = 1'b1;
                            resp_port = win_b;
                            resp_data = (!w_we && !oor) ? mem_rd_i : '0;
`ifdef DMEM_CTRL_ERR_EN
                            resp_err  = oor;
`endif
                        end
                    end
                end
                RMW_WR: begin
                    mem_we_o   = 1'b1;
                    mem_addr_o = cap_addr_q;
                    mem_wd_o   = merged;
                    state_d    = IDLE;
                    resp_v     = 1'b1;
                    resp_port  = cap_port_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            cap_rd_q   <= '0;
            cap_wd_q   <= '0;
            cap_be_q   <= '0;
            cap_addr_q <= '0;
            cap_port_q <= 1'b0;
            a_rvalid_o <= 1'b0;
            a_rdata_o  <= '0;
            b_rvalid_o <= 1'b0;
            b_rdata_o  <= '0;
        end else begin
            state_q <= state_d;
            if (!b_req_i || b_gnt_o) begin
                wait_q <= '0;
            end else if (state_q == IDLE && wait_q != WAIT_MAX) begin
                wait_q <= wait_q + CW'(1);
            end
            if (partial) begin
                cap_rd_q   <= mem_rd_i;
                cap_wd_q   <= w_wd;
                cap_be_q   <= w_be;
                cap_addr_q <= {w_addr[ADDR_WIDTH-1:2], 2'b00};
                cap_port_q <= win_b;
            end
            a_rvalid_o <= resp_v && !resp_port;
            b_rvalid_o <= resp_v && resp_port;
            if (resp_v && !resp_port) a_rdata_o <= resp_data;
            if (resp_v && resp_port)  b_rdata_o <= resp_data;
        end
    end

`ifdef DMEM_CTRL_ERR_EN
    logic a_err_q, b_err_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
        end else begin
            if (resp_v && !resp_port) a_err_q <= resp_err;
            if (resp_v && resp_port)  b_err_q <= resp_err;
        end
    end

    assign a_err_o = a_err_q;
    assign b_err_o = b_err_q;
`else
    assign a_err_o = 1'b0;
    assign b_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a word memory model and a per-port
// response scoreboard.
module tb_dmem_ctrl;

`ifdef DMEM_CTRL_ERR_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wd, b_addr, b_wd;
    logic [3:0]  a_be, b_be;
    logic        a_gnt_o, a_rvalid_o, a_err_o;
    logic        b_gnt_o, b_rvalid_o, b_err_o;
    logic [31:0] a_rdata_o, b_rdata_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd_i = (mem_addr_o < 32'd4096) ? mem[mem_addr_o[11:2]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (mem_we_o && mem_addr_o < 32'd4096) mem[mem_addr_o[11:2]] <= mem_wd_o;
    end

    dmem_ctrl dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .a_req_i    (a_req),
        .a_we_i     (a_we),
        .a_addr_i   (a_addr),
        .a_wd_i     (a_wd),
        .a_be_i     (a_be),
        .a_gnt_o    (a_gnt_o),
        .a_rvalid_o (a_rvalid_o),
        .a_rdata_o  (a_rdata_o),
        .a_err_o    (a_err_o),
        .b_req_i    (b_req),
        .b_we_i     (b_we),
        .b_addr_i   (b_addr),
        .b_wd_i     (b_wd),
        .b_be_i     (b_be),
        .b_gnt_o    (b_gnt_o),
        .b_rvalid_o (b_rvalid_o),
        .b_rdata_o  (b_rdata_o),
        .b_err_o    (b_err_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wd_o   (mem_wd_o),
        .mem_rd_i   (mem_rd_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] d, input bit e, input int c);
        exp_t x;
        x.d = d;
        x.e = e;
        x.cyc = c;
        if (port) qb.push_back(x);
        else qa.push_back(x);
    endtask

    // Call at posedge+1; returns at the negedge of the grant cycle, request still held.
    task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] ed, input bit ee, input int lat);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wd = wd; b_be = be;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wd = wd; a_be = be;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port ? b_gnt_o : a_gnt_o) === 1'b1) begin
                push(port, ed, ee, cyc + lat);
                return;
            end
        end
        chk(port ? "b_gnt_timeout" : "a_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic rel();
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst_i) begin
            if (a_rvalid_o) begin
                if (qa.size() == 0) chk("a_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    x = qa.pop_front();
                    chk("a_rdata", a_rdata_o, x.d);
                    chk("a_err", {31'd0, a_err_o}, {31'd0, x.e});
                    chk("a_latency", cyc, x.cyc);
                end
            end
            if (b_rvalid_o) begin
                if (qb.size() == 0) chk("b_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    x = qb.pop_front();
                    chk("b_rdata", b_rdata_o, x.d);
                    chk("b_err", {31'd0, b_err_o}, {31'd0, x.e});
                    chk("b_latency", cyc, x.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wd = 32'h1; a_be = 4'hF;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20; b_wd = 32'h0; b_be = 4'h0;
        for (int i = 0; i < 1024; i++) mem[i] <= {16'hA5A5, 16'(i)};
        mem[8]  <= 32'h11223344;
        mem[12] <= 32'hCAFEF00D;
        mem[16] <= 32'h55667788;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_gnt", {31'd0, a_gnt_o}, 32'd0);
        chk("rst_b_gnt", {31'd0, b_gnt_o}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid_o}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid_o}, 32'd0);
        chk("rst_a_rdata", a_rdata_o, 32'd0);
        chk("rst_b_rdata", b_rdata_o, 32'd0);
        chk("rst_errs", {30'd0, a_err_o, b_err_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        #1;

        // full write then read back, aligned and unaligned
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 1);
        chk("full_wr_we", {31'd0, mem_we_o}, 32'd1);
        chk("full_wr_wd", mem_wd_o, 32'hDEADBEEF);
        chk("full_wr_addr", mem_addr_o, 32'h10);
        rel();
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1);
        chk("rd_we", {31'd0, mem_we_o}, 32'd0);
        rel();
        issue(0, 0, 32'h13, 32'h0, 4'b0101, 32'hDEADBEEF, 1'b0, 1);
        chk("rd_unaligned_addr", mem_addr_o, 32'h10);
        rel();

        // sub-word store: read, then merged write
        issue(1, 1, 32'h20, 32'h0000AA00, 4'b0010, 32'd0, 1'b0, 2);
        chk("rmw_accept_we", {31'd0, mem_we_o}, 32'd0);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        @(negedge clk);
        chk("rmw_we", {31'd0, mem_we_o}, 32'd1);
        chk("rmw_wd", mem_wd_o, 32'h1122AA44);
        chk("rmw_addr", mem_addr_o, 32'h20);
        @(posedge clk);
        #1;
        issue(1, 0, 32'h20, 32'h0, 4'h0, 32'h1122AA44, 1'b0, 1);
        rel();
        chk("rmw_mem", mem[8], 32'h1122AA44);

        // zero byte-enable write: ack only
        issue(0, 1, 32'h24, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 1);
        chk("be0_we", {31'd0, mem_we_o}, 32'd0);
        rel();
        chk("be0_mem", mem[9], 32'hA5A50009);

        // A blocked during B's RMW, granted in the ack cycle
        issue(1, 1, 32'h30, 32'h000000EE, 4'b0001, 32'd0, 1'b0, 2);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_be = 4'h0;
        @(negedge clk);
        chk("rmw_block_a_gnt", {31'd0, a_gnt_o}, 32'd0);
        chk("rmw_block_b_gnt", {31'd0, b_gnt_o}, 32'd0);
        chk("rmw2_wd", mem_wd_o, 32'hCAFEF0EE);
        @(posedge clk);
        #1;
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1);
        chk("a_gnt_in_ack_cycle", {31'd0, b_rvalid_o}, 32'd1);
        rel();
        chk("rmw2_mem", mem[12], 32'hCAFEF0EE);

        // starvation: A wins MAX_WAIT times, then B once, then A
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_be = 4'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20; b_be = 4'h0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("arb_a", {31'd0, a_gnt_o}, (i == 8) ? 32'd0 : 32'd1);
            chk("arb_b", {31'd0, b_gnt_o}, (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) push(1, 32'h1122AA44, 1'b0, cyc + 1);
            else push(0, 32'hDEADBEEF, 1'b0, cyc + 1);
        end
        rel();

        // out-of-range accesses
        issue(0, 0, 32'd4096, 32'h0, 4'hF, 32'd0, EE, 1);
        rel();
        issue(0, 1, 32'd4096, 32'h12345678, 4'hF, 32'd0, EE, 1);
        chk("oor_full_we", {31'd0, mem_we_o}, 32'd0);
        rel();
        issue(1, 1, 32'd4100, 32'h0000BBBB, 4'b0011, 32'd0, EE, 1);
        chk("oor_part_we", {31'd0, mem_we_o}, 32'd0);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        @(negedge clk);
        chk("oor_no_rmw", {31'd0, mem_we_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("oor_mem0", mem[0], 32'hA5A50000);
        chk("oor_mem1", mem[1], 32'hA5A50001);

        // reset in RMW_WR abandons the write
        issue(1, 1, 32'h40, 32'h99000000, 4'b1000, 32'd0, 1'b0, 2);
        @(posedge clk);
        #1;
        b_req = 1'b0;
        chk("pre_rst_rmw_we", {31'd0, mem_we_o}, 32'd1);
        rst_i = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        #1;
        void'(qb.pop_back());
        chk("rst_rmw_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_rmw_gnt", {30'd0, a_gnt_o, b_gnt_o}, 32'd0);
        chk("rst_rmw_rvalid", {30'd0, a_rvalid_o, b_rvalid_o}, 32'd0);
        chk("rst_rmw_rdata", a_rdata_o | b_rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rmw_mem", mem[16], 32'h55667788);
        rst_i = 1'b0;
        a_req = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 0, 32'h40, 32'h0, 4'h0, 32'h55667788, 1'b0, 1);
        rel();

        repeat (3) @(posedge clk);
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
